alsu_res_fifo: RTL

ALSU_RES_FIFO -- requirements
Module: alsu_res_fifo

---
 rtl/alsu_res_pkg.sv | 16 +
 rtl/alsu_res_mem.sv | 24 ++
 rtl/alsu_res_fifo.sv | 101 ++++++++++
 3 files changed

// File: rtl/alsu_res_pkg.sv
// Shared constants and width helpers for the ALSU result FIFO.
// Optional feature macro: ALSU_RES_ERR_DROP_EN (drop errored results).
package alsu_res_pkg;

    localparam int DEF_BITS  = 3;
    localparam int DEF_DEPTH = 4;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/alsu_res_mem.sv
// Result storage: register array, one write port, one async read port.
// Optional feature macro: ALSU_RES_ERR_DROP_EN (unused here).
module alsu_res_mem #(
    parameter int W     = 7,
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [PW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alsu_res_fifo.sv
// Result FIFO behind the ALSU with sticky overflow and error tagging.
// Optional feature macro: ALSU_RES_ERR_DROP_EN (errored results discarded).
module alsu_res_fifo
    import alsu_res_pkg::*;
#(
    parameter int BITS  = DEF_BITS,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [2*BITS-1:0]         in_data,
    input  logic                      in_err,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*BITS-1:0]         out_data,
    output logic                      out_err,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow,
    input  logic                      clr_ovf
);

    localparam int W  = 2 * BITS;
    localparam int CW = cnt_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          acc, wbit, push, pop, drop;
    logic [W:0]    head;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef ALSU_RES_ERR_DROP_EN
    assign acc  = in_valid & ~in_err;
    assign wbit = 1'b0;
`else
    assign acc  = in_valid;
    assign wbit = in_err;
`endif

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(DEPTH));
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    // a pop frees the slot the same cycle, so a full FIFO still accepts
    assign push      = acc & (~full | pop);
    assign drop      = acc & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop)  rd_ptr <= nxt(rd_ptr);
            if (push && !pop)
                cnt_q <= cnt_q + CW'(1);
            else if (pop && !push)
                cnt_q <= cnt_q - CW'(1);
            if (drop)
                ovf_q <= 1'b1;
            else if (clr_ovf)
                ovf_q <= 1'b0;
        end
    end

    alsu_res_mem #(
        .W     (W + 1),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({wbit, in_data}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // storage is not reset; gate the head so an empty FIFO presents zeros
    assign out_data = empty ? '0 : head[W-1:0];
    assign count    = cnt_q;
    assign overflow = ovf_q;

`ifdef ALSU_RES_ERR_DROP_EN
    logic unused_err;
    assign unused_err = head[W];
    assign out_err    = 1'b0;
`else
    assign out_err = empty ? 1'b0 : head[W];
`endif

endmodule
